// File: rtl/psram_access_arbiter_if.sv
// Bus bundle between the two PSRAM requesters, the arbiter and the PSRAM controller command port.
// Handshake: a requester holds rq high while it wants the memory and may pulse cmd_en only
// while its ack is high; each cmd_en cycle is one command, and there is no ready back-pressure.
interface psram_access_arbiter_if #(
  parameter int ADDR_WIDTH = 21
);
  logic                  mem_ready;
  logic                  wr_rq;
  logic                  wr_cmd_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_ack;
  logic                  rd_rq;
  logic                  rd_cmd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ack;
  logic                  mem_cmd_en;
  logic                  mem_cmd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  err_cmd;
  logic                  err_timeout;

  modport slave (
    input  mem_ready,
    input  wr_rq, wr_cmd_en, wr_addr,
    input  rd_rq, rd_cmd_en, rd_addr,
    output wr_ack, rd_ack,
    output mem_cmd_en, mem_cmd, mem_addr,
    output err_cmd, err_timeout
  );

  modport master (
    output mem_ready,
    output wr_rq, wr_cmd_en, wr_addr,
    output rd_rq, rd_cmd_en, rd_addr,
    input  wr_ack, rd_ack,
    input  mem_cmd_en, mem_cmd, mem_addr,
    input  err_cmd, err_timeout
  );
endinterface

// File: rtl/psram_access_arbiter.sv
// Two-requester round-robin arbiter for a single PSRAM command port, with a bounded hold time
// per grant and sticky error flags for stray strobes and forced releases.
module psram_access_arbiter #(
  parameter int ADDR_WIDTH = 21,
  parameter int MAX_HOLD   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  psram_access_arbiter_if.slave bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic [7:0]            hold_q, hold_d;
  logic                  timeout_hit;
  logic                  wr_ack_q, rd_ack_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  err_cmd_q, err_timeout_q;

  logic                  in_grant;
  logic                  owner_rq;
  logic                  owner_cmd_en;
  logic [ADDR_WIDTH-1:0] owner_addr;
  logic                  stray_strobe;

  assign in_grant     = (state_q == GRANT);
  assign owner_rq     = owner_q ? bus.rd_rq     : bus.wr_rq;
  assign owner_cmd_en = owner_q ? bus.rd_cmd_en : bus.wr_cmd_en;
  assign owner_addr   = owner_q ? bus.rd_addr   : bus.wr_addr;

  // Any strobe that does not come from the current owner during GRANT is dropped and flagged.
  assign stray_strobe = (bus.wr_cmd_en && !(in_grant && !owner_q)) ||
                        (bus.rd_cmd_en && !(in_grant &&  owner_q));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    hold_d       = hold_q;
    timeout_hit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_ready && (bus.wr_rq || bus.rd_rq)) begin
          state_d = GRANT;
          hold_d  = 8'd0;
          if (bus.wr_rq && bus.rd_rq) owner_d = ~last_owner_q;
          else                        owner_d = bus.rd_rq;
        end
      end
      GRANT: begin
        if (hold_q != 8'hFF) hold_d = hold_q + 8'd1;
        if (!owner_rq) begin
          state_d = RELEASE;
        end else if (hold_q == HOLD_LAST) begin
          state_d     = RELEASE;
          timeout_hit = 1'b1;
        end
      end
      RELEASE: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_owner_q  <= 1'b1;
      hold_q        <= 8'd0;
      wr_ack_q      <= 1'b0;
      rd_ack_q      <= 1'b0;
      addr_q        <= '0;
      err_cmd_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      hold_q       <= hold_d;
      wr_ack_q     <= (state_d == GRANT) && !owner_d;
      rd_ack_q     <= (state_d == GRANT) &&  owner_d;
      // Remember the owner's last address so mem_addr stays stable between grants.
      if (in_grant) addr_q <= owner_addr;
      if (stray_strobe) err_cmd_q     <= 1'b1;
      if (timeout_hit)  err_timeout_q <= 1'b1;
    end
  end

  assign bus.wr_ack      = wr_ack_q;
  assign bus.rd_ack      = rd_ack_q;
  assign bus.mem_cmd_en  = in_grant && owner_cmd_en;
  assign bus.mem_cmd     = in_grant && !owner_q;
  assign bus.mem_addr    = in_grant ? owner_addr : addr_q;
  assign bus.err_cmd     = err_cmd_q;
  assign bus.err_timeout = err_timeout_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_psram_access_arbiter.sv
// Directed bench for psram_access_arbiter with MAX_HOLD = 4 so forced releases are short.
module tb_psram_access_arbiter;

  localparam int AW = 21;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:0] exp_q[$];

  psram_access_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  psram_access_arbiter #(.ADDR_WIDTH(AW), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.wr_rq     = 1'b0;
    bus.wr_cmd_en = 1'b0;
    bus.wr_addr   = '0;
    bus.rd_rq     = 1'b0;
    bus.rd_cmd_en = 1'b0;
    bus.rd_addr   = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic capture_grant(output logic who, output int len);
    int waited = 0;
    who = 1'b0;
    len = 0;
    while (!(bus.wr_ack || bus.rd_ack) && waited < 30) begin
      tick();
      waited++;
    end
    check_eq("grant_seen", 32'(bus.wr_ack || bus.rd_ack), 32'd1);
    check_eq("ack_one_hot", 32'(bus.wr_ack && bus.rd_ack), 32'd0);
    who = bus.rd_ack;
    while ((who ? bus.rd_ack : bus.wr_ack) && len < 300) begin
      len++;
      tick();
    end
  endtask

  initial begin
    logic who;
    int   len;
    int   seen;
    int   waited;

    // write-only grant, zero-latency forwarding, strobe on the cycle rq drops
    apply_reset();
    check_eq("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
    check_eq("rst_rd_ack", 32'(bus.rd_ack), 32'd0);
    check_eq("rst_cmd_en", 32'(bus.mem_cmd_en), 32'd0);
    check_eq("rst_cmd", 32'(bus.mem_cmd), 32'd0);
    check_eq("rst_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst_err_cmd", 32'(bus.err_cmd), 32'd0);
    check_eq("rst_err_to", 32'(bus.err_timeout), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    bus.mem_ready = 1'b1;
    bus.wr_rq     = 1'b1;
    bus.rd_addr   = 21'h00ABC;
    #1 check_eq("w_no_ack_yet", 32'(bus.wr_ack), 32'd0);
    tick();
    check_eq("w_ack", 32'(bus.wr_ack), 32'd1);
    check_eq("w_rd_ack_low", 32'(bus.rd_ack), 32'd0);
    check_eq("w_state_grant", 32'(dbg_state), 32'd1);
    bus.wr_cmd_en = 1'b1;
    bus.wr_addr   = 21'h1F000;
    #1;
    check_eq("w_cmd_en", 32'(bus.mem_cmd_en), 32'd1);
    check_eq("w_cmd", 32'(bus.mem_cmd), 32'd1);
    check_eq("w_addr", 32'(bus.mem_addr), 32'h1F000);
    tick();
    bus.wr_addr = 21'h00123;
    bus.wr_rq   = 1'b0;
    #1;
    check_eq("drop_strobe_fwd", 32'(bus.mem_cmd_en), 32'd1);
    check_eq("drop_strobe_addr", 32'(bus.mem_addr), 32'h00123);
    tick();
    bus.wr_cmd_en = 1'b0;
    #1;
    check_eq("rel_state", 32'(dbg_state), 32'd2);
    check_eq("rel_wr_ack", 32'(bus.wr_ack), 32'd0);
    check_eq("rel_cmd_en", 32'(bus.mem_cmd_en), 32'd0);
    check_eq("rel_addr_hold", 32'(bus.mem_addr), 32'h00123);
    tick();
    check_eq("back_idle", 32'(dbg_state), 32'd0);
    check_eq("w_err_cmd", 32'(bus.err_cmd), 32'd0);
    check_eq("w_err_to", 32'(bus.err_timeout), 32'd0);

    // tie from reset: write first, then read after a 2-cycle gap
    apply_reset();
    bus.mem_ready = 1'b1;
    bus.wr_rq     = 1'b1;
    bus.rd_rq     = 1'b1;
    tick();
    check_eq("tie_w_first", 32'(bus.wr_ack), 32'd1);
    check_eq("tie_r_wait", 32'(bus.rd_ack), 32'd0);
    bus.wr_rq = 1'b0;
    tick();
    check_eq("tie_release", 32'(dbg_state), 32'd2);
    check_eq("tie_rel_acks", 32'(bus.wr_ack | bus.rd_ack), 32'd0);
    tick();
    check_eq("tie_idle", 32'(dbg_state), 32'd0);
    check_eq("tie_idle_rd_ack", 32'(bus.rd_ack), 32'd0);
    tick();
    check_eq("tie_r_ack", 32'(bus.rd_ack), 32'd1);
    check_eq("tie_r_wr_low", 32'(bus.wr_ack), 32'd0);
    bus.rd_cmd_en = 1'b1;
    bus.rd_addr   = 21'h0ABCD;
    #1;
    check_eq("r_cmd_en", 32'(bus.mem_cmd_en), 32'd1);
    check_eq("r_cmd", 32'(bus.mem_cmd), 32'd0);
    check_eq("r_addr", 32'(bus.mem_addr), 32'h0ABCD);
    bus.rd_rq = 1'b0;
    tick();
    bus.rd_cmd_en = 1'b0;
    tick();
    check_eq("tie_err_cmd", 32'(bus.err_cmd), 32'd0);

    // sustained requests: W,R,W each forced out after 4 cycles
    apply_reset();
    exp_q = {1'b0, 1'b1, 1'b0};
    bus.mem_ready = 1'b1;
    bus.wr_rq     = 1'b1;
    bus.rd_rq     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      capture_grant(who, len);
      check_eq("rr_owner", 32'(who), 32'(exp_q.pop_front()));
      check_eq("rr_hold_len", 32'(len), 32'd4);
    end
    check_eq("rr_err_to", 32'(bus.err_timeout), 32'd1);
    check_eq("rr_err_cmd", 32'(bus.err_cmd), 32'd0);

    // illegal strobe from the non-owner during a write grant
    apply_reset();
    bus.mem_ready = 1'b1;
    bus.wr_rq     = 1'b1;
    tick();
    bus.rd_cmd_en = 1'b1;
    bus.rd_addr   = 21'h00055;
    bus.wr_addr   = 21'h00777;
    #1;
    check_eq("ill_blocked", 32'(bus.mem_cmd_en), 32'd0);
    check_eq("ill_addr_owner", 32'(bus.mem_addr), 32'h00777);
    tick();
    bus.rd_cmd_en = 1'b0;
    check_eq("ill_err_cmd", 32'(bus.err_cmd), 32'd1);
    bus.wr_rq = 1'b0;
    repeat (4) tick();
    check_eq("ill_err_sticky", 32'(bus.err_cmd), 32'd1);

    // strobe with no grant at all
    apply_reset();
    bus.wr_cmd_en = 1'b1;
    #1 check_eq("idle_strobe_blocked", 32'(bus.mem_cmd_en), 32'd0);
    tick();
    bus.wr_cmd_en = 1'b0;
    check_eq("idle_strobe_err", 32'(bus.err_cmd), 32'd1);

    // mem_ready gating, then ready dropping mid-grant keeps the grant
    apply_reset();
    bus.wr_rq = 1'b1;
    bus.rd_rq = 1'b1;
    seen = 0;
    repeat (12) begin
      tick();
      if (bus.wr_ack || bus.rd_ack) seen++;
    end
    check_eq("not_ready_no_ack", 32'(seen), 32'd0);
    bus.mem_ready = 1'b1;
    tick();
    check_eq("ready_grant", 32'(bus.wr_ack), 32'd1);
    bus.mem_ready = 1'b0;
    tick();
    check_eq("ready_drop_keeps", 32'(bus.wr_ack), 32'd1);
    check_eq("ready_drop_state", 32'(dbg_state), 32'd1);

    // both flags set, then asynchronous reset in the middle of a grant
    apply_reset();
    bus.mem_ready = 1'b1;
    bus.wr_rq     = 1'b1;
    tick();
    bus.rd_cmd_en = 1'b1;
    tick();
    bus.rd_cmd_en = 1'b0;
    waited = 0;
    while (!bus.err_timeout && waited < 20) begin
      tick();
      waited++;
    end
    check_eq("ar_err_to", 32'(bus.err_timeout), 32'd1);
    waited = 0;
    while (!bus.wr_ack && waited < 20) begin
      tick();
      waited++;
    end
    check_eq("ar_regrant", 32'(bus.wr_ack), 32'd1);
    bus.wr_cmd_en = 1'b1;
    bus.wr_addr   = 21'h1F000;
    #1;
    check_eq("ar_pre_cmd_en", 32'(bus.mem_cmd_en), 32'd1);
    check_eq("ar_pre_err_cmd", 32'(bus.err_cmd), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("ar_wr_ack", 32'(bus.wr_ack), 32'd0);
    check_eq("ar_cmd_en", 32'(bus.mem_cmd_en), 32'd0);
    check_eq("ar_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("ar_err_cmd", 32'(bus.err_cmd), 32'd0);
    check_eq("ar_err_to", 32'(bus.err_timeout), 32'd0);
    check_eq("ar_state", 32'(dbg_state), 32'd0);
    bus.wr_cmd_en = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    check_eq("ar_idle_after", 32'(dbg_state), 32'd0);
    tick();
    check_eq("ar_restart_grant", 32'(bus.wr_ack), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
